// File: rtl/io_port_unit.sv
// Memory-mapped I/O for the single-cycle MIPS core: N output channels, a debounced
// confirm button and a halt/capture FSM that stalls the PC while an IN waits for it.
module io_port_unit #(
  parameter int                DATA_W   = 32,
  parameter int                SW_W     = 16,
  parameter int                N_OUT    = 4,
  parameter int                ADDR_W   = 10,
  parameter logic [ADDR_W-1:0] IO_BASE  = 10'h3F0,
  parameter int                DEB_CYC  = 4,
  parameter int                SIGN_EXT = 1,
  localparam int               SEL_W    = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_req,
  input  logic [SW_W-1:0]   switches,
  input  logic              btn,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              mem_write,
  input  logic [SEL_W-1:0]  disp_sel,
  output logic              halt,
  output logic [DATA_W-1:0] in_data,
  output logic              in_valid,
  output logic              dm_we,
  output logic [N_OUT-1:0]  out_strobe,
  output logic [DATA_W-1:0] disp_data,
  output logic [3:0]        last_ch,
  output logic [1:0]        dbg_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_CAPT = 2'd2;

  localparam int               CNT_W    = $clog2(DEB_CYC + 1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYC - 1);

  logic             sync1, sync2, btn_db, btn_db_d, press;
  logic [CNT_W-1:0] deb_cnt;

  // btn_db only follows the synchronised level after DEB_CYC consecutive disagreeing cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      btn_db   <= 1'b0;
      btn_db_d <= 1'b0;
      deb_cnt  <= '0;
    end else begin
      sync1    <= btn;
      sync2    <= sync1;
      btn_db_d <= btn_db;
      if (sync2 != btn_db) begin
        if (deb_cnt == DEB_LAST) begin
          btn_db  <= sync2;
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  assign press = btn_db & ~btn_db_d;

  logic [1:0]        state, state_nxt;
  logic [DATA_W-1:0] ext_sw;

  always_comb begin
    ext_sw             = {DATA_W{(SIGN_EXT != 0) && switches[SW_W-1]}};
    ext_sw[SW_W-1:0]   = switches;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (in_req) state_nxt = S_WAIT;
      S_WAIT:  if (press)  state_nxt = S_CAPT;
      S_CAPT:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      in_data <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_WAIT && press) in_data <= ext_sw;
    end
  end

  // halt is combinational so the PC stalls in the very cycle the IN is decoded.
  assign halt      = ~rst & (((state == S_IDLE) & in_req) | (state == S_WAIT));
  assign in_valid  = (state == S_CAPT);
  assign dbg_state = state;

  logic [DATA_W-1:0] out_reg [N_OUT];
  logic [ADDR_W-1:0] offset;
  logic              hit;
  logic [3:0]        ch;

  // Unsigned wrap makes addresses below IO_BASE land far outside the window.
  assign offset = addr - IO_BASE;
  assign hit    = mem_write && (offset < ADDR_W'(N_OUT));
  assign ch     = offset[3:0];
  assign dm_we  = mem_write & ~hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_OUT; k++) out_reg[k] <= '0;
      out_strobe <= '0;
      last_ch    <= '0;
    end else begin
      out_strobe <= '0;
      if (hit) begin
        last_ch <= ch;
        for (int k = 0; k < N_OUT; k++) begin
          if (ch == 4'(k)) begin
            out_reg[k]    <= wdata;
            out_strobe[k] <= 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    disp_data = '0;
    if (int'(disp_sel) < N_OUT) disp_data = out_reg[disp_sel];
  end

endmodule

// File: tb/tb_io_port_unit.sv
// Directed bench for io_port_unit: table of store vectors plus hand-written IN/button sequences.
module tb_io_port_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_req;
  logic [15:0] switches;
  logic        btn;
  logic [9:0]  addr;
  logic [31:0] wdata;
  logic        mem_write;
  logic [1:0]  disp_sel;
  logic        halt;
  logic [31:0] in_data;
  logic        in_valid;
  logic        dm_we;
  logic [3:0]  out_strobe;
  logic [31:0] disp_data;
  logic [3:0]  last_ch;
  logic [1:0]  dbg_state;

  int compared = 0;
  int failed   = 0;
  logic [31:0] exp_q[$];

  io_port_unit dut (
    .clk(clk), .rst(rst), .in_req(in_req), .switches(switches), .btn(btn),
    .addr(addr), .wdata(wdata), .mem_write(mem_write), .disp_sel(disp_sel),
    .halt(halt), .in_data(in_data), .in_valid(in_valid), .dm_we(dm_we),
    .out_strobe(out_strobe), .disp_data(disp_data), .last_ch(last_ch),
    .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running, expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // scoreboard: every in_valid pulse must match the oldest expected capture
  always @(negedge clk) begin
    if (!rst && in_valid) begin
      if (exp_q.size() == 0) begin
        compared++;
        failed++;
        $display("FAIL in_valid_unexpected: got pulse with in_data %h expected none", in_data);
      end else begin
        check("in_data", in_data, exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int exp_edges, input string nm);
    int n = 0;
    while (n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (in_valid) break;
      check({nm, "_halt_wait"}, 32'(halt), 32'd1);
    end
    check({nm, "_latency"}, 32'(n), 32'(exp_edges));
    check({nm, "_valid"}, 32'(in_valid), 32'd1);
    check({nm, "_halt_capt"}, 32'(halt), 32'd0);
  endtask

  task automatic release_btn();
    btn = 1'b0;
    tick(10);
  endtask

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic        we;
    logic [1:0]  sel;
    logic        exp_dm_we;
    logic [3:0]  exp_strobe;
    logic [3:0]  exp_last;
    logic [31:0] exp_disp;
  } vec_t;

  vec_t tbl[10];

  initial begin
    tbl[0] = '{10'h3F2, 32'd1234,       1'b1, 2'd2, 1'b0, 4'b0100, 4'd2, 32'd1234};
    tbl[1] = '{10'h3F4, 32'hDEAD_BEEF,  1'b1, 2'd2, 1'b1, 4'b0000, 4'd2, 32'd1234};
    tbl[2] = '{10'h010, 32'd5,          1'b1, 2'd0, 1'b1, 4'b0000, 4'd2, 32'd0};
    tbl[3] = '{10'h3F0, 32'hAAAA_5555,  1'b1, 2'd0, 1'b0, 4'b0001, 4'd0, 32'hAAAA_5555};
    tbl[4] = '{10'h3F3, 32'd77,         1'b0, 2'd3, 1'b0, 4'b0000, 4'd0, 32'd0};
    tbl[5] = '{10'h3F3, 32'h1234_5678,  1'b1, 2'd3, 1'b0, 4'b1000, 4'd3, 32'h1234_5678};
    tbl[6] = '{10'h3EF, 32'd9,          1'b1, 2'd1, 1'b1, 4'b0000, 4'd3, 32'd0};
    tbl[7] = '{10'h3F1, 32'hFFFF_FFFF,  1'b1, 2'd2, 1'b0, 4'b0010, 4'd1, 32'd1234};
    tbl[8] = '{10'h000, 32'd0,          1'b0, 2'd1, 1'b0, 4'b0000, 4'd1, 32'hFFFF_FFFF};
    tbl[9] = '{10'h3FF, 32'd3,          1'b1, 2'd0, 1'b1, 4'b0000, 4'd1, 32'hAAAA_5555};

    rst = 1'b1; btn = 1'b1; switches = 16'hFFFF; in_req = 1'b1;
    addr = '0; wdata = '0; mem_write = 1'b0; disp_sel = 2'd0;

    // Reset: everything zero, halt forced low even with in_req high
    tick(3);
    check("rst_halt", 32'(halt), 32'd0);
    check("rst_in_data", in_data, 32'd0);
    check("rst_in_valid", 32'(in_valid), 32'd0);
    check("rst_strobe", 32'(out_strobe), 32'd0);
    check("rst_last_ch", 32'(last_ch), 32'd0);
    check("rst_disp", disp_data, 32'd0);
    check("rst_dm_we", 32'(dm_we), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    in_req = 1'b0;
    rst = 1'b0;
    // Button held through reset debounces high outside WAIT_BTN and is discarded
    tick(12);
    check("held_btn_state", 32'(dbg_state), 32'd0);
    release_btn();

    // Clean press, sign-extended capture
    in_req = 1'b1; switches = 16'h8001;
    #1;
    check("in_req_halt", 32'(halt), 32'd1);
    exp_q.push_back(32'hFFFF_8001);
    btn = 1'b1;
    wait_valid(7, "clean");
    in_req = 1'b0;
    tick(1);
    check("after_capt_state", 32'(dbg_state), 32'd0);
    release_btn();

    // Bouncy button: 1,0 then stable 1 -> one press, latency counted from the stable edge
    in_req = 1'b1; switches = 16'h0042;
    exp_q.push_back(32'h0000_0042);
    btn = 1'b1; tick(1);
    btn = 1'b0; tick(1);
    btn = 1'b1;
    wait_valid(7, "bouncy");
    // in_req held again with button still down: no fresh edge, so no capture
    tick(10);
    check("held_halt", 32'(halt), 32'd1);
    check("held_state", 32'(dbg_state), 32'd1);
    check("held_valid", 32'(in_valid), 32'd0);
    btn = 1'b0;
    tick(10);
    switches = 16'hC3A5;
    exp_q.push_back(32'hFFFF_C3A5);
    btn = 1'b1;
    wait_valid(7, "fresh");
    in_req = 1'b0;
    tick(1);
    release_btn();

    // Press arriving in the same cycle that in_req first rises is ignored
    btn = 1'b1;
    tick(6);
    in_req = 1'b1; switches = 16'h0003;
    tick(10);
    check("coincide_state", 32'(dbg_state), 32'd1);
    check("coincide_halt", 32'(halt), 32'd1);
    release_btn();
    exp_q.push_back(32'h0000_0003);
    btn = 1'b1;
    wait_valid(7, "coincide_retry");
    in_req = 1'b0;
    tick(1);
    release_btn();

    // Reset in the middle of WAIT_BTN with in_req held
    in_req = 1'b1; switches = 16'h1111;
    tick(3);
    check("mid_wait_state", 32'(dbg_state), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_halt", 32'(halt), 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'd0);
    tick(2);
    rst = 1'b0;
    #1;
    check("post_rst_halt", 32'(halt), 32'd1);
    tick(3);
    check("post_rst_wait", 32'(dbg_state), 32'd1);
    switches = 16'h7FFE;
    exp_q.push_back(32'h0000_7FFE);
    btn = 1'b1;
    wait_valid(7, "post_rst");
    in_req = 1'b0;
    tick(1);
    release_btn();

    // Store path: table of vectors, dm_we checked before the edge, registers after it
    for (int i = 0; i < 10; i++) begin
      addr = tbl[i].addr; wdata = tbl[i].wdata; mem_write = tbl[i].we; disp_sel = tbl[i].sel;
      #1;
      check($sformatf("v%0d_dm_we", i), 32'(dm_we), 32'(tbl[i].exp_dm_we));
      tick(1);
      check($sformatf("v%0d_strobe", i), 32'(out_strobe), 32'(tbl[i].exp_strobe));
      check($sformatf("v%0d_last_ch", i), 32'(last_ch), 32'(tbl[i].exp_last));
      check($sformatf("v%0d_disp", i), disp_data, tbl[i].exp_disp);
    end
    mem_write = 1'b0;
    tick(2);

    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
